lbp_win_sched: RTL and testbench

- Sequencing controller for the LBP datapath's 3x3 window over a square grayscale image held in external memory.
- Walks every interior centre pixel in raster order and issues gray memory reads.
- Fetches 9 pixels at the start of each row, then reuses columns so each later centre needs only 3 reads.
- Drives the window register file load/shift controls, then pulses lbp_valid with the centre address for the LBP comparator and writer.

---
 rtl/lbp_pkg.sv | 22 ++
 rtl/lbp_win_addr_gen.sv | 38 +++
 rtl/lbp_win_sched.sv | 124 ++++++++++++
 tb/tb_lbp_win_sched.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP 3x3 window sequencer: state encoding,
// default geometry and the window slots that receive a freshly fetched column.
package lbp_pkg;

    localparam int IMG_W_DEF  = 128;
    localparam int ADDR_W_DEF = 14;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FILL = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        STEP = 3'd4,
        DONE = 3'd5
    } state_t;

    // Column +1 of the window, rows -1, 0, +1.
    localparam logic [3:0] SLOT_NEW0 = 4'd6;
    localparam logic [3:0] SLOT_NEW1 = 4'd7;
    localparam logic [3:0] SLOT_NEW2 = 4'd8;

endpackage

// File: rtl/lbp_win_addr_gen.sv
// Maps a window centre (r, c) and a column-major slot 0..8 to the pixel
// address (r+dr)*IMG_W + (c+dc), using a shift because IMG_W is a power of two.
module lbp_win_addr_gen #(
    parameter int ADDR_W = 14
) (
    input  logic [ADDR_W/2-1:0] r,
    input  logic [ADDR_W/2-1:0] c,
    input  logic [3:0]          slot,
    output logic [ADDR_W-1:0]   addr
);

    localparam int LW = ADDR_W / 2;

    logic [1:0]    ci;
    logic [1:0]    ri;
    logic [LW-1:0] row;
    logic [LW-1:0] col;

    always_comb begin
        {ci, ri} = 4'b0000;
        case (slot)
            4'd1:    {ci, ri} = 4'b0001;
            4'd2:    {ci, ri} = 4'b0010;
            4'd3:    {ci, ri} = 4'b0100;
            4'd4:    {ci, ri} = 4'b0101;
            4'd5:    {ci, ri} = 4'b0110;
            4'd6:    {ci, ri} = 4'b1000;
            4'd7:    {ci, ri} = 4'b1001;
            4'd8:    {ci, ri} = 4'b1010;
            default: {ci, ri} = 4'b0000;
        endcase
        // Index 0..2 encodes offset -1..+1; centres are interior so no wrap occurs.
        row  = r + LW'(ri) - LW'(1);
        col  = c + LW'(ci) - LW'(1);
        addr = (ADDR_W'(row) << LW) + ADDR_W'(col);
    end

endmodule

// File: rtl/lbp_win_sched.sv
// Raster-order 3x3 window sequencer: full 9-pixel fill at each row start,
// then one-column shift plus 3 reads per centre, one lbp_valid pulse per centre.
module lbp_win_sched
    import lbp_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              win_we,
    output logic [3:0]        win_idx,
    output logic              win_shift,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic              finish,
    output state_t            dbg_state
);

    localparam int LW = ADDR_W / 2;
    localparam logic [LW-1:0] LAST = LW'(IMG_W - 2);

    state_t        state, state_n;
    logic [LW-1:0] r, r_n, c, c_n;
    logic [3:0]    cnt, cnt_n;
    logic [3:0]    slot;
    logic [ADDR_W-1:0] gen_addr;

    lbp_win_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .r    (r),
        .c    (c),
        .slot (slot),
        .addr (gen_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            r       <= LW'(1);
            c       <= LW'(1);
            cnt     <= 4'd0;
            win_we  <= 1'b0;
            win_idx <= 4'd0;
        end else begin
            state   <= state_n;
            r       <= r_n;
            c       <= c_n;
            cnt     <= cnt_n;
            // Memory returns data one cycle after the request.
            win_we  <= gray_req;
            win_idx <= gray_req ? slot : 4'd0;
        end
    end

    always_comb begin
        state_n   = state;
        r_n       = r;
        c_n       = c;
        cnt_n     = cnt;
        gray_req  = 1'b0;
        slot      = 4'd0;
        win_shift = 1'b0;
        lbp_valid = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (gray_ready) begin
                    state_n = FILL;
                    cnt_n   = 4'd0;
                end
            end
            FILL: begin
                gray_req = 1'b1;
                slot     = cnt;
                if (cnt == 4'd8) begin
                    state_n = WAIT;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            WAIT: state_n = EMIT;
            EMIT: begin
                lbp_valid = 1'b1;
                cnt_n     = 4'd0;
                if (r == LAST && c == LAST) begin
                    state_n = DONE;
                end else if (c == LAST) begin
                    r_n     = r + LW'(1);
                    c_n     = LW'(1);
                    state_n = FILL;
                end else begin
                    c_n     = c + LW'(1);
                    state_n = STEP;
                end
            end
            STEP: begin
                gray_req  = 1'b1;
                win_shift = (cnt == 4'd0);
                case (cnt)
                    4'd0:    slot = SLOT_NEW0;
                    4'd1:    slot = SLOT_NEW1;
                    default: slot = SLOT_NEW2;
                endcase
                if (cnt == 4'd2) begin
                    state_n = WAIT;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            DONE:    finish = 1'b1;
            default: state_n = IDLE;
        endcase
    end

    assign gray_addr = gray_req ? gen_addr : '0;
    assign lbp_addr  = lbp_valid ? ((ADDR_W'(r) << LW) + ADDR_W'(c)) : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_lbp_win_sched.sv
// Bench for lbp_win_sched: a per-cycle expected trace built from the raster
// walk rules, compared against the DUT on every falling edge.
module tb_lbp_win_sched;
    import lbp_pkg::*;

    localparam int IMG_W  = 128;
    localparam int ADDR_W = 14;
    localparam int EW     = 35;

    logic              clk = 1'b0;
    logic              reset;
    logic              gray_ready;
    logic              gray_req;
    logic [ADDR_W-1:0] gray_addr;
    logic              win_we;
    logic [3:0]        win_idx;
    logic              win_shift;
    logic              lbp_valid;
    logic [ADDR_W-1:0] lbp_addr;
    logic              finish;
    state_t            dbg_state;

    always #5 clk = ~clk;

    lbp_win_sched #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .win_we     (win_we),
        .win_idx    (win_idx),
        .win_shift  (win_shift),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .finish     (finish),
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Entry: {req[34], addr[33:20], slot[19:16], shift[15], valid[14], lbp_addr[13:0]}
    logic [EW-1:0] exp_q[$];
    int            lbp_list[$];
    int            mode = 2;  // 0: expect idle zeros, 1: follow trace, 2: unchecked

    logic          prev_req;
    logic [3:0]    prev_slot;
    logic [EW-1:0] e;
    int pulses, last_laddr, cyc, first_req_cyc, finish_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int pix(input int r, input int c, input int dr, input int dc);
        return (r + dr) * IMG_W + (c + dc);
    endfunction

    function automatic logic [EW-1:0] mk(input bit req, input int addr, input int slot,
                                         input bit sh, input bit v, input int la);
        return {req, 14'(addr), 4'(slot), sh, v, 14'(la)};
    endfunction

    // Whole-image trace: each cycle's outputs from leaving IDLE to entering DONE.
    task automatic build_model();
        exp_q.delete();
        lbp_list.delete();
        for (int r = 1; r <= IMG_W - 2; r++) begin
            for (int c = 1; c <= IMG_W - 2; c++) begin
                if (c == 1) begin
                    for (int dc = -1; dc <= 1; dc++)
                        for (int dr = -1; dr <= 1; dr++)
                            exp_q.push_back(mk(1, pix(r, c, dr, dc), 3*(dc+1) + (dr+1), 0, 0, 0));
                end else begin
                    for (int dr = -1; dr <= 1; dr++)
                        exp_q.push_back(mk(1, pix(r, c, dr, 1), 6 + (dr+1), dr == -1, 0, 0));
                end
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1, pix(r, c, 0, 0)));
                lbp_list.push_back(pix(r, c, 0, 0));
            end
        end
    endtask

    always @(negedge clk) begin
        if (mode == 0) begin
            check("idle_outputs",
                  {29'd0, gray_req, gray_addr, win_we, win_idx, win_shift, lbp_valid, lbp_addr, finish},
                  64'd0);
        end else if (mode == 1) begin
            cyc++;
            if (gray_req && first_req_cyc < 0) first_req_cyc = cyc;
            if (finish && finish_cyc < 0) finish_cyc = cyc;
            if (lbp_valid) begin
                pulses++;
                last_laddr = int'(lbp_addr);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gray_req", gray_req, e[34]);
                if (e[34]) check("gray_addr", gray_addr, e[33:20]);
                check("win_shift", win_shift, e[15]);
                check("lbp_valid", lbp_valid, e[14]);
                if (e[14]) check("lbp_addr", lbp_addr, e[13:0]);
                check("finish_early", finish, 0);
                check("win_we", win_we, prev_req);
                if (prev_req) check("win_idx", win_idx, prev_slot);
                prev_req  = e[34];
                prev_slot = e[19:16];
            end else begin
                check("done_finish", finish, 1);
                check("done_quiet", {gray_req, win_shift, lbp_valid}, 0);
                check("done_win_we", win_we, prev_req);
                prev_req = 1'b0;
            end
        end
    end

    task automatic start_run();
        @(negedge clk);
        #1;
        gray_ready    = 1'b1;
        build_model();
        prev_req      = 1'b0;
        prev_slot     = 4'd0;
        cyc           = 0;
        first_req_cyc = -1;
        finish_cyc    = -1;
        pulses        = 0;
        last_laddr    = -1;
        mode          = 1;
    endtask

    int fill_tab[9] = '{0, 128, 256, 1, 129, 257, 2, 130, 258};

    initial begin
        reset      = 1'b0;
        gray_ready = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_outputs",
              {29'd0, gray_req, gray_addr, win_we, win_idx, win_shift, lbp_valid, lbp_addr, finish},
              64'd0);
        check("reset_state", 64'(dbg_state), 64'(IDLE));
        #1;
        reset = 1'b1;
        mode  = 0;
        repeat (20) @(negedge clk);

        // Abort in the second STEP cycle, then restart from scratch.
        repeat ($urandom_range(0, 4)) @(negedge clk);
        start_run();
        @(negedge clk);
        #1 gray_ready = 1'b0;
        repeat (12) @(negedge clk);
        #2;
        check("pre_reset_in_step", 64'(dbg_state), 64'(STEP));
        mode  = 2;
        reset = 1'b0;
        #1;
        check("async_reset_drop",
              {29'd0, gray_req, gray_addr, win_we, win_idx, win_shift, lbp_valid, lbp_addr, finish},
              64'd0);
        check("async_reset_state", 64'(dbg_state), 64'(IDLE));
        repeat (3) @(negedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        mode  = 0;
        repeat ($urandom_range(3, 8)) @(negedge clk);

        // Full image with gray_ready toggling randomly once running.
        start_run();
        for (int i = 0; i < 9; i++) check("model_fill_addr", exp_q[i][33:20], fill_tab[i]);
        check("model_first_lbp", exp_q[10][13:0], 129);
        check("model_first_lbp_valid", exp_q[10][14], 1);
        check("model_step_shift", exp_q[11][15], 1);
        check("model_step_addr0", exp_q[11][33:20], 3);
        check("model_step_addr1", exp_q[12][33:20], 131);
        check("model_step_addr2", exp_q[13][33:20], 259);
        check("model_second_lbp", exp_q[15][13:0], 130);
        check("model_row_end_lbp", 64'(lbp_list[125]), 254);
        check("model_wrap_addr", exp_q[636][33:20], 128);
        check("model_wrap_noshift", exp_q[636][15], 0);
        check("model_wrap_lbp", 64'(lbp_list[126]), 257);
        check("model_cycles", 64'(exp_q.size()), 80136);
        check("model_pulses", 64'(lbp_list.size()), 15876);
        for (int i = 0; i < 81000 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1 gray_ready = 1'($urandom_range(0, 1));
        end
        check("run_timeout", 64'(exp_q.size()), 0);
        repeat (10) begin
            @(negedge clk);
            #1 gray_ready = 1'($urandom_range(0, 1));
        end
        check("lbp_pulse_count", 64'(pulses), 15876);
        check("last_lbp_addr", 64'(last_laddr), 16254);
        check("first_req_to_finish", 64'(finish_cyc - first_req_cyc), 80136);
        mode = 2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
